glitch_result_checker: RTL and testbench
========================================

Name: glitch_result_checker

Overview:
- Sits directly downstream of the one-cycle glitched delay stage, in the glitched_clk domain.
- Keeps a copy of every byte sent into that stage and compares it against the byte that comes out, counting mismatches caused by clock glitches.
- Detects lost and extra bytes.
- On request, serialises a 5-byte status report to the UART transmit path over a valid/ready handshake.

Parameters:
- DEPTH, 4, entries in the reference FIFO (power of two, ≥2)
- HDR_BYTE, 8'hA5, first byte of every report

Ports:
- glitched_clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- ref_dv  in  1  byte entering the delay stage is valid this cycle
- ref_data  in  8  byte entering the delay stage
- stage_dv  in  1  delay-stage output valid
- stage_data  in  8  delay-stage output byte
- clr  in  1  synchronous pulse: clear counters and sticky flags
- report_req  in  1  pulse: start a report
- tx_ready  in  1  UART TX can accept a byte
- tx_valid  out  1  report byte valid
- tx_byte  out  8  report byte
- busy  out  1  report in progress
- mismatch  out  1  one-cycle pulse per detected mismatch

Behaviour:
- Reset (rst low, asynchronous) clears the following; everything is re-initialised when rst deasserts mid-report, and no partial report resumes.
  - Outputs: tx_valid, tx_byte, busy and mismatch all 0.
  - Internal state: FIFO empty, byte_cnt=0, err_cnt=0, ovf=0, extra=0, FSM in IDLE.
- Reference FIFO:
  - ref_dv pushes ref_data.
  - stage_dv pops the head.
  - Push when full with no pop in the same cycle: byte dropped, ovf set (sticky).
  - Push and pop in the same cycle while full: both are performed; no overflow.
  - stage_dv while empty: no compare, extra set (sticky). A simultaneous ref_dv is still pushed; the pop never bypasses to the incoming byte.
  - Pointers wrap modulo DEPTH; full/empty are tracked with an occupancy count of 0..DEPTH.
- Compare, when stage_dv is high and the FIFO is non-empty:
  - Compare stage_data against the head.
  - byte_cnt (16-bit) increments, saturating at 16'hFFFF.
  - On inequality, err_cnt (8-bit) increments, saturating at 8'hFF, and mismatch pulses high in the next cycle (1-cycle registered latency).
  - Counter updates are visible one cycle after stage_dv.
- clr:
  - Zeroes byte_cnt, err_cnt, ovf and extra in the next cycle; FIFO contents are kept.
  - clr coincident with a compare: clear wins; that compare is not counted, but its mismatch pulse still fires.
- Report FSM: states IDLE, HDR, CNT_H, CNT_L, ERR, FLAGS.
  - IDLE with report_req: snapshot byte_cnt, err_cnt, ovf, extra and (FIFO non-empty), using register values before any same-cycle update. Then go to HDR, busy=1, tx_valid=1.
  - Bytes, in order:
    - HDR = HDR_BYTE
    - CNT_H = byte_cnt[15:8]
    - CNT_L = byte_cnt[7:0]
    - ERR = err_cnt
    - FLAGS = {5'b0, fifo_nonempty, extra, ovf}
  - Each state holds tx_valid and tx_byte stable until tx_valid and tx_ready are both high, then advances next cycle.
  - FLAGS accepted → IDLE, tx_valid=0 and busy=0 in the following cycle.
  - report_req while busy is ignored.
  - clr during a report does not alter the snapshot being sent.
  - Checking continues in parallel with reporting.
- Minimum report duration: 5 cycles with tx_ready held high.

Test Plan:
1. Clean stream: 6 back-to-back bytes 8'h01..8'h06 on ref_dv, echoed one cycle later on stage_dv → byte_cnt=6, err_cnt=0, no mismatch pulse, FIFO empty at end.
2. Glitch: ref bytes 8'h3C,8'h5A; stage returns 8'h3C,8'h5B → exactly one mismatch pulse, one cycle after the second stage_dv; err_cnt=1, byte_cnt=2.
3. Boundaries, each a separate run:
   - 5 ref_dv pushes with no stage_dv → ovf=1, occupancy 4.
   - stage_dv on an empty FIFO → extra=1, byte_cnt unchanged.
   - Push+pop while full → ovf stays 0.
4. Report with tx_ready toggling 1,0,1,1,0,1,1 after byte_cnt=16'h0102, err_cnt=3, ovf=1 → bytes A5,01,02,03,01 with tx_byte stable while tx_ready=0. A second report_req mid-report is ignored.
5. Saturation and clr:
   - 256 mismatches → err_cnt=8'hFF.
   - clr during an active report → report still sends FF; a subsequent report sends err_cnt=00.
6. Async reset: assert rst mid-report (state CNT_L) off a clock edge → tx_valid, busy and mismatch drop to 0 immediately. After release, the FSM is in IDLE and all counters read 0 in the next report.

Source files
------------

// File: rtl/glitch_result_checker.sv
// rtl/glitch_result_checker.sv - compares glitched delay-stage output against a reference FIFO and reports status
module glitch_result_checker #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic       glitched_clk,
  input  logic       rst,
  input  logic       ref_dv,
  input  logic [7:0] ref_data,
  input  logic       stage_dv,
  input  logic [7:0] stage_data,
  input  logic       clr,
  input  logic       report_req,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {IDLE, HDR, CNT_H, CNT_L, ERR, FLAGS} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   byte_cnt;
  logic [7:0]    err_cnt;
  logic          ovf, extra;

  state_t        state, state_nx;
  logic [15:0]   snap_bc;
  logic [7:0]    snap_ec;
  logic [2:0]    snap_flags;

  logic fifo_full, fifo_empty, pop, push, ovf_hit, extra_hit, cmp_neq;

  assign fifo_full  = (count == FULL);
  assign fifo_empty = (count == '0);
  // A pop never bypasses to the byte being pushed in the same cycle.
  assign pop        = stage_dv && !fifo_empty;
  assign push       = ref_dv && (!fifo_full || pop);
  assign ovf_hit    = ref_dv && fifo_full && !pop;
  assign extra_hit  = stage_dv && fifo_empty;
  assign cmp_neq    = pop && (stage_data != mem[rd_ptr]);

  always_ff @(posedge glitched_clk) begin
    if (push) mem[wr_ptr] <= ref_data;
  end

  always_ff @(posedge glitched_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // clr takes priority over any same-cycle compare or sticky event; mismatch still pulses.
  always_ff @(posedge glitched_clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
      extra    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= cmp_neq;
      if (clr) begin
        byte_cnt <= '0;
        err_cnt  <= '0;
        ovf      <= 1'b0;
        extra    <= 1'b0;
      end else begin
        if (pop && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        if (cmp_neq && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (ovf_hit)   ovf   <= 1'b1;
        if (extra_hit) extra <= 1'b1;
      end
    end
  end

  always_ff @(posedge glitched_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap_bc    <= '0;
      snap_ec    <= '0;
      snap_flags <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && report_req) begin
        snap_bc    <= byte_cnt;
        snap_ec    <= err_cnt;
        snap_flags <= {!fifo_empty, extra, ovf};
      end
    end
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_byte  = 8'h00;
    unique case (state)
      IDLE: begin
        if (report_req) state_nx = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_byte  = HDR_BYTE;
        if (tx_ready) state_nx = CNT_H;
      end
      CNT_H: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_byte  = snap_bc[15:8];
        if (tx_ready) state_nx = CNT_L;
      end
      CNT_L: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_byte  = snap_bc[7:0];
        if (tx_ready) state_nx = ERR;
      end
      ERR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_byte  = snap_ec;
        if (tx_ready) state_nx = FLAGS;
      end
      FLAGS: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_byte  = {5'b0, snap_flags};
        if (tx_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_glitch_result_checker.sv
// tb/tb_glitch_result_checker.sv - self-checking bench for glitch_result_checker
module tb_glitch_result_checker;

  localparam int DEPTH = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic       glitched_clk;
  logic       rst;
  logic       ref_dv, stage_dv, clr, report_req, tx_ready;
  logic [7:0] ref_data, stage_data;
  logic       tx_valid, busy, mismatch;
  logic [7:0] tx_byte;

  glitch_result_checker #(.DEPTH(DEPTH), .HDR_BYTE(HDR)) dut (
    .glitched_clk(glitched_clk),
    .rst(rst),
    .ref_dv(ref_dv),
    .ref_data(ref_data),
    .stage_dv(stage_dv),
    .stage_data(stage_data),
    .clr(clr),
    .report_req(report_req),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_byte(tx_byte),
    .busy(busy),
    .mismatch(mismatch)
  );

  initial begin
    glitched_clk = 1'b0;
    forever #5 glitched_clk = ~glitched_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Behavioural model: FIFO as a queue, counters as integers, report as a byte queue.
  logic [7:0] mq[$];
  logic [7:0] rep_q[$];
  int         m_bc = 0;
  int         m_ec = 0;
  bit         m_ovf = 0;
  bit         m_extra = 0;
  bit         m_mism = 0;

  task automatic model_step();
    bit cmp, neq, ovf_evt;
    cmp = stage_dv && (mq.size() > 0);
    neq = cmp && (stage_data != mq[0]);
    if (rep_q.size() == 0) begin
      if (report_req) begin
        rep_q.push_back(HDR);
        rep_q.push_back(8'(m_bc >> 8));
        rep_q.push_back(8'(m_bc));
        rep_q.push_back(8'(m_ec));
        rep_q.push_back({5'b0, mq.size() > 0, m_extra, m_ovf});
      end
    end else if (tx_ready) begin
      void'(rep_q.pop_front());
    end
    m_mism = neq;
    if (!clr && stage_dv && mq.size() == 0) m_extra = 1;
    ovf_evt = 0;
    if (cmp) void'(mq.pop_front());
    if (ref_dv) begin
      if (mq.size() < DEPTH) mq.push_back(ref_data);
      else ovf_evt = 1;
    end
    if (clr) begin
      m_bc = 0; m_ec = 0; m_ovf = 0; m_extra = 0;
    end else begin
      if (cmp && m_bc < 65535) m_bc++;
      if (neq && m_ec < 255) m_ec++;
      if (ovf_evt) m_ovf = 1;
    end
  endtask

  initial forever begin
    @(posedge glitched_clk or negedge rst);
    if (!rst) begin
      mq.delete(); rep_q.delete();
      m_bc = 0; m_ec = 0; m_ovf = 0; m_extra = 0; m_mism = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare plus logging of accepted bytes and mismatch pulses.
  logic [7:0] got[$];
  int         mism_cnt = 0;

  initial forever begin
    @(negedge glitched_clk);
    if (rst) begin
      check("tx_valid", tx_valid, rep_q.size() != 0);
      check("busy", busy, rep_q.size() != 0);
      check("tx_byte", tx_byte, (rep_q.size() != 0) ? rep_q[0] : 8'h00);
      check("mismatch", mismatch, m_mism);
      if (tx_valid && tx_ready) got.push_back(tx_byte);
      if (mismatch) mism_cnt++;
    end
  end

  task automatic tick();
    @(posedge glitched_clk);
    #1;
  endtask

  task automatic idle_inputs();
    ref_dv = 0; ref_data = 0; stage_dv = 0; stage_data = 0;
    clr = 0; report_req = 0; tx_ready = 0;
  endtask

  task automatic pulse_clr();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic check_got(string name, int base, logic [39:0] exp);
    check({name, "_len"}, got.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < got.size())
        check($sformatf("%s_b%0d", name, i), got[base + i], exp[39 - 8*i -: 8]);
  endtask

  task automatic run_report(string name, logic [39:0] exp, bit mid_clr);
    int base, n;
    base = got.size();
    report_req = 1; tx_ready = 1; tick();
    report_req = 0; clr = mid_clr; tick();
    clr = 0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    if (busy) check({name, "_timeout"}, busy, 0);
    tx_ready = 0;
    tick();
    check_got(name, base, exp);
  endtask

  initial begin
    int base, m0;
    idle_inputs();
    rst = 0;
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    rst = 1;
    tick();

    // 1: clean stream echoed one cycle later
    m0 = mism_cnt;
    for (int i = 0; i < 7; i++) begin
      ref_dv = (i < 6); ref_data = 8'(i + 1);
      stage_dv = (i > 0); stage_data = 8'(i);
      tick();
    end
    idle_inputs(); tick();
    check("t1_mism_cnt", mism_cnt - m0, 0);
    run_report("t1", {HDR, 8'h00, 8'h06, 8'h00, 8'h00}, 0);

    // 2: single glitched byte
    pulse_clr();
    m0 = mism_cnt;
    ref_dv = 1; ref_data = 8'h3C; tick();
    ref_data = 8'h5A; stage_dv = 1; stage_data = 8'h3C; tick();
    ref_dv = 0; stage_data = 8'h5B; tick();
    stage_dv = 0;
    check("t2_pulse_hi", mismatch, 1);
    tick();
    check("t2_pulse_lo", mismatch, 0);
    check("t2_mism_cnt", mism_cnt - m0, 1);
    run_report("t2", {HDR, 8'h00, 8'h02, 8'h01, 8'h00}, 0);

    // 3a: overflow
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      ref_dv = 1; ref_data = 8'(8'h11 + i); tick();
    end
    idle_inputs(); tick();
    check("t3a_occupancy", mq.size(), 4);
    run_report("t3a", {HDR, 8'h00, 8'h00, 8'h00, 8'h05}, 0);

    // 3b: drain, then stage_dv on an empty FIFO
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      stage_dv = 1; stage_data = 8'(8'h11 + i); tick();
    end
    stage_dv = 1; stage_data = 8'hEE; tick();
    idle_inputs(); tick();
    run_report("t3b", {HDR, 8'h00, 8'h04, 8'h00, 8'h02}, 0);

    // 3c: push and pop while full
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      ref_dv = 1; ref_data = 8'(8'h20 + i); tick();
    end
    ref_dv = 1; ref_data = 8'h24; stage_dv = 1; stage_data = 8'h20; tick();
    idle_inputs(); tick();
    run_report("t3c", {HDR, 8'h00, 8'h01, 8'h00, 8'h04}, 0);
    for (int i = 1; i < 5; i++) begin
      stage_dv = 1; stage_data = 8'(8'h20 + i); tick();
    end
    idle_inputs(); tick();

    // 4: byte_cnt=0x0102, err_cnt=3, ovf=1 with tx_ready toggling
    pulse_clr();
    for (int i = 0; i < 255; i++) begin
      ref_dv = (i < 254); ref_data = 8'(i);
      stage_dv = (i > 0);
      stage_data = 8'(i - 1) ^ ((i - 1 == 10 || i - 1 == 100 || i - 1 == 200) ? 8'h01 : 8'h00);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      ref_dv = 1; ref_data = 8'(8'h30 + i); tick();
    end
    ref_dv = 0;
    for (int i = 0; i < 4; i++) begin
      stage_dv = 1; stage_data = 8'(8'h30 + i); tick();
    end
    idle_inputs(); tick();
    base = got.size();
    report_req = 1; tick();
    report_req = 0;
    for (int k = 0; k < 7; k++) begin
      tx_ready = (k != 1 && k != 4);
      report_req = (k == 2 || k == 6);
      tick();
      if (k == 1) check("t4_hold_cnt_h", tx_byte, 8'h01);
      if (k == 4) check("t4_hold_err", tx_byte, 8'h03);
    end
    idle_inputs();
    check("t4_busy_done", busy, 0);
    tick();
    check("t4_no_restart", busy, 0);
    check_got("t4", base, {HDR, 8'h01, 8'h02, 8'h03, 8'h01});

    // 5: err_cnt saturation, clr during a report
    pulse_clr();
    m0 = mism_cnt;
    for (int i = 0; i < 257; i++) begin
      ref_dv = (i < 256); ref_data = 8'(i);
      stage_dv = (i > 0); stage_data = ~8'(i - 1);
      tick();
    end
    idle_inputs(); tick();
    check("t5_mism_cnt", mism_cnt - m0, 256);
    run_report("t5_sat", {HDR, 8'h01, 8'h00, 8'hFF, 8'h00}, 1);
    run_report("t5_after_clr", {HDR, 8'h00, 8'h00, 8'h00, 8'h00}, 0);

    // 6: asynchronous reset mid-report with a mismatch pulse live
    ref_dv = 1; ref_data = 8'h77; tick();
    ref_dv = 0;
    report_req = 1; tick();
    report_req = 0; tx_ready = 1; tick();
    stage_dv = 1; stage_data = 8'h78; tick();
    stage_dv = 0; tx_ready = 0;
    check("t6_pre_valid", tx_valid, 1);
    check("t6_pre_byte", tx_byte, 8'h00);
    check("t6_pre_mismatch", mismatch, 1);
    #2 rst = 0;
    #1;
    check("t6_rst_valid", tx_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mismatch", mismatch, 0);
    idle_inputs();
    repeat (2) tick();
    rst = 1;
    tick();
    check("t6_idle", busy, 0);
    run_report("t6_post", {HDR, 8'h00, 8'h00, 8'h00, 8'h00}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
